// File: rtl/display_scheduler.sv
// display_scheduler: picks what the 4-digit score display shows (live score,
// high score or a transient flash value) and when it blanks, based on the
// current game state. All outputs are registered, one cycle after the inputs.
//
// Handshake: flash_req is a single-cycle request with no ready. It is accepted
// only while the game is RUNNING and the mode is not changing in the same
// cycle. flash_value is captured on acceptance, and flash_ack pulses for
// exactly one cycle on the following clock. A newer request restarts the
// flash hold with the newer value.
//
// disp_src mirrors the FSM state encoding (00 score, 01 high, 10 flash), so it
// doubles as the state observation point.
module display_scheduler #(
    parameter int CNT_W        = 28,
    parameter int ALT_CYCLES   = 200000000,
    parameter int BLINK_CYCLES = 25000000,
    parameter int FLASH_CYCLES = 50000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] score_in,
    input  logic [15:0] high_score_in,
    input  logic [1:0]  game_state_in,
    input  logic        flash_req,
    input  logic [15:0] flash_value,
    output logic        flash_ack,
    output logic [15:0] disp_value,
    output logic        disp_blank,
    output logic [1:0]  disp_src,
    output logic        new_record
);

    typedef enum logic [1:0] {
        S_SCORE = 2'b00,
        S_HIGH  = 2'b01,
        S_FLASH = 2'b10
    } state_t;

    localparam logic [1:0] GS_IDLE   = 2'b00;
    localparam logic [1:0] GS_RUN    = 2'b01;
    localparam logic [1:0] GS_PAUSED = 2'b10;
    localparam logic [1:0] GS_OVER   = 2'b11;

    // Terminal counts: every counter wraps to 0 here, so none can overflow.
    localparam logic [CNT_W-1:0] ALT_TC   = CNT_W'(ALT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLINK_TC = CNT_W'(BLINK_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLASH_TC = CNT_W'(FLASH_CYCLES - 1);

    state_t             r_state;
    logic [1:0]         r_gs_q;
    logic [CNT_W-1:0]   r_timer;
    logic [CNT_W-1:0]   r_blink_cnt;
    logic               r_blink_phase;
    logic [15:0]        r_flash_reg;
    logic [15:0]        r_disp_value;
    logic               r_disp_blank;
    logic [1:0]         r_disp_src;
    logic               r_flash_ack;
    logic               r_new_record;

    state_t             w_state;
    logic               w_mode_change;
    logic [CNT_W-1:0]   w_timer;
    logic [CNT_W-1:0]   w_blink_cnt;
    logic               w_blink_phase;
    logic [15:0]        w_flash_reg;
    logic               w_flash_ack;
    logic               w_new_record;
    logic               w_disp_blank;
    logic [15:0]        w_disp_value;

    // Next-state logic: mode changes restart everything, otherwise each mode
    // runs its own dwell / flash / blink sequencing.
    always_comb begin
        w_mode_change = (game_state_in != r_gs_q);
        w_state       = r_state;
        w_timer       = r_timer;
        w_blink_cnt   = '0;
        w_blink_phase = 1'b0;
        w_flash_reg   = r_flash_reg;
        w_flash_ack   = 1'b0;

        if (w_mode_change) begin
            // A pending flash is dropped and a same-cycle request is ignored.
            w_state = S_SCORE;
            w_timer = '0;
        end else begin
            case (r_gs_q)
                GS_IDLE, GS_OVER: begin
                    if (r_timer == ALT_TC) begin
                        w_timer = '0;
                        w_state = (r_state == S_SCORE) ? S_HIGH : S_SCORE;
                    end else begin
                        w_timer = r_timer + 1'b1;
                    end
                end
                GS_RUN: begin
                    if (flash_req) begin
                        w_flash_reg = flash_value;
                        w_flash_ack = 1'b1;
                        w_state     = S_FLASH;
                        w_timer     = '0;
                    end else if (r_state == S_FLASH) begin
                        if (r_timer == FLASH_TC) begin
                            w_state = S_SCORE;
                            w_timer = '0;
                        end else begin
                            w_timer = r_timer + 1'b1;
                        end
                    end else begin
                        w_state = S_SCORE;
                        w_timer = '0;
                    end
                end
                default: begin
                    w_state = S_SCORE;
                    w_timer = '0;
                end
            endcase

            // The blink counter is independent of the dwell timer so OVER can
            // alternate and blink at the same time.
            if (r_gs_q == GS_PAUSED || r_gs_q == GS_OVER) begin
                if (r_blink_cnt == BLINK_TC) begin
                    w_blink_cnt   = '0;
                    w_blink_phase = ~r_blink_phase;
                end else begin
                    w_blink_cnt   = r_blink_cnt + 1'b1;
                    w_blink_phase = r_blink_phase;
                end
            end
        end

        w_new_record = (game_state_in == GS_OVER) && (score_in > high_score_in);

        case (game_state_in)
            GS_PAUSED: w_disp_blank = w_blink_phase;
            GS_OVER:   w_disp_blank = w_blink_phase & w_new_record;
            default:   w_disp_blank = 1'b0;
        endcase

        case (w_state)
            S_HIGH:  w_disp_value = high_score_in;
            S_FLASH: w_disp_value = w_flash_reg;
            default: w_disp_value = score_in;
        endcase
    end

    // State, counters and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_SCORE;
            r_gs_q        <= GS_IDLE;
            r_timer       <= '0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_flash_reg   <= '0;
            r_disp_value  <= '0;
            r_disp_blank  <= 1'b0;
            r_disp_src    <= 2'b00;
            r_flash_ack   <= 1'b0;
            r_new_record  <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_gs_q        <= game_state_in;
            r_timer       <= w_timer;
            r_blink_cnt   <= w_blink_cnt;
            r_blink_phase <= w_blink_phase;
            r_flash_reg   <= w_flash_reg;
            r_disp_value  <= w_disp_value;
            r_disp_blank  <= w_disp_blank;
            r_disp_src    <= w_state;
            r_flash_ack   <= w_flash_ack;
            r_new_record  <= w_new_record;
        end
    end

    assign flash_ack  = r_flash_ack;
    assign disp_value = r_disp_value;
    assign disp_blank = r_disp_blank;
    assign disp_src   = r_disp_src;
    assign new_record = r_new_record;

endmodule

// File: tb/tb_display_scheduler.sv
// Bench for display_scheduler with short dwell/blink/flash times.
module tb_display_scheduler;

    localparam int ALT   = 8;
    localparam int BLINK = 4;
    localparam int FLASH = 6;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] score_in;
    logic [15:0] high_score_in;
    logic [1:0]  game_state_in;
    logic        flash_req;
    logic [15:0] flash_value;
    logic        flash_ack;
    logic [15:0] disp_value;
    logic        disp_blank;
    logic [1:0]  disp_src;
    logic        new_record;

    display_scheduler #(
        .CNT_W(28), .ALT_CYCLES(ALT), .BLINK_CYCLES(BLINK), .FLASH_CYCLES(FLASH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .score_in(score_in),
        .high_score_in(high_score_in), .game_state_in(game_state_in),
        .flash_req(flash_req), .flash_value(flash_value), .flash_ack(flash_ack),
        .disp_value(disp_value), .disp_blank(disp_blank), .disp_src(disp_src),
        .new_record(new_record)
    );

    // clock
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference model: cycles since the current mode was entered, plus the
    // start time and value of the newest accepted flash
    logic [1:0]  m_gs;
    int          m_n;
    bit          m_f_act;
    int          m_f_start;
    logic [15:0] m_f_val;

    // expected {value[16], src[2], blank, ack, new_record}
    logic [20:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_gs      = 2'b00;
        m_n       = 0;
        m_f_act   = 1'b0;
        m_f_start = 0;
        m_f_val   = '0;
        exp_q.delete();
    endtask

    // Expected outputs after the next clock edge, from the inputs applied now.
    task automatic model_edge(input logic [1:0] gs, input logic [15:0] sc, input logic [15:0] hs,
                              input logic req, input logic [15:0] fv);
        logic [15:0] v;
        logic [1:0]  s;
        logic        bl, ak, nr, ph;
        ak = 1'b0;
        if (gs != m_gs) begin
            m_gs    = gs;
            m_n     = 0;
            m_f_act = 1'b0;
        end else begin
            m_n++;
            if (gs == 2'd1 && req) begin
                m_f_act   = 1'b1;
                m_f_start = m_n;
                m_f_val   = fv;
                ak        = 1'b1;
            end
        end
        if (m_f_act && (m_n - m_f_start) >= FLASH) m_f_act = 1'b0;
        ph = ((m_n / BLINK) % 2) != 0;
        nr = (gs == 2'd3) && (sc > hs);
        case (gs)
            2'd0, 2'd3: begin
                if (((m_n / ALT) % 2) != 0) begin v = hs; s = 2'd1; end
                else begin v = sc; s = 2'd0; end
            end
            2'd1: begin
                if (m_f_act) begin v = m_f_val; s = 2'd2; end
                else begin v = sc; s = 2'd0; end
            end
            default: begin v = sc; s = 2'd0; end
        endcase
        if (gs == 2'd2)      bl = ph;
        else if (gs == 2'd3) bl = ph & nr;
        else                 bl = 1'b0;
        exp_q.push_back({v, s, bl, ak, nr});
    endtask

    // One clock of stimulus, modelled and scored.
    task automatic step(input logic [1:0] gs, input logic [15:0] sc, input logic [15:0] hs,
                        input logic req, input logic [15:0] fv);
        logic [20:0] e;
        @(negedge clk);
        game_state_in = gs;
        score_in      = sc;
        high_score_in = hs;
        flash_req     = req;
        flash_value   = fv;
        model_edge(gs, sc, hs, req, fv);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_eq("disp_value", disp_value, e[20:5]);
        check_eq("disp_src", {14'd0, disp_src}, {14'd0, e[4:3]});
        check_eq("disp_blank", {15'd0, disp_blank}, {15'd0, e[2]});
        check_eq("flash_ack", {15'd0, flash_ack}, {15'd0, e[1]});
        check_eq("new_record", {15'd0, new_record}, {15'd0, e[0]});
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_value"}, disp_value, 16'd0);
        check_eq({tag, "_src"}, {14'd0, disp_src}, 16'd0);
        check_eq({tag, "_blank"}, {15'd0, disp_blank}, 16'd0);
        check_eq({tag, "_ack"}, {15'd0, flash_ack}, 16'd0);
        check_eq({tag, "_record"}, {15'd0, new_record}, 16'd0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [1:0]  gs;
        logic [15:0] sc, hs;
        int          len;

        reset_n       = 1'b0;
        game_state_in = 2'b00;
        score_in      = '0;
        high_score_in = '0;
        flash_req     = 1'b0;
        flash_value   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        release_reset();

        // IDLE alternation 5 / 42
        repeat (20) step(2'd0, 16'd5, 16'd42, 1'b0, 16'd0);

        // RUNNING: request on the mode-change cycle is not acked
        step(2'd1, 16'd7, 16'd42, 1'b1, 16'd55);
        step(2'd1, 16'd7, 16'd42, 1'b0, 16'd0);
        // single flash of 100
        step(2'd1, 16'd7, 16'd42, 1'b1, 16'd100);
        repeat (8) step(2'd1, 16'd7, 16'd42, 1'b0, 16'd0);
        // back-to-back flashes 100 then 200
        step(2'd1, 16'd7, 16'd42, 1'b1, 16'd100);
        repeat (2) step(2'd1, 16'd7, 16'd42, 1'b0, 16'd0);
        step(2'd1, 16'd7, 16'd42, 1'b1, 16'd200);
        repeat (8) step(2'd1, 16'd7, 16'd42, 1'b0, 16'd0);

        // PAUSED blink, flash request ignored
        repeat (6) step(2'd2, 16'd9, 16'd42, 1'b0, 16'd0);
        step(2'd2, 16'd9, 16'd42, 1'b1, 16'd300);
        repeat (8) step(2'd2, 16'd9, 16'd42, 1'b0, 16'd0);

        // OVER with a new record, then an equal score (not a record)
        repeat (20) step(2'd3, 16'd50, 16'd30, 1'b0, 16'd0);
        repeat (12) step(2'd3, 16'd30, 16'd30, 1'b1, 16'd1);

        // reset in the middle of a flash
        step(2'd1, 16'd11, 16'd3, 1'b0, 16'd0);
        step(2'd1, 16'd11, 16'd3, 1'b1, 16'd77);
        repeat (2) step(2'd1, 16'd11, 16'd3, 1'b0, 16'd0);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_zero_outputs("async_reset");
        repeat (2) @(posedge clk);
        release_reset();
        repeat (10) step(2'd1, 16'd11, 16'd3, 1'b0, 16'd0);

        // randomized mode segments
        for (int seg = 0; seg < 40; seg++) begin
            gs  = 2'($urandom_range(0, 3));
            len = $urandom_range(3, 30);
            for (int c = 0; c < len; c++) begin
                if ($urandom_range(0, 3) == 0) begin
                    sc = 16'($urandom);
                    hs = 16'($urandom);
                end else begin
                    sc = 16'($urandom_range(0, 5));
                    hs = 16'($urandom_range(0, 5));
                end
                step(gs, sc, hs, ($urandom_range(0, 4) == 0), 16'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
